// File: rtl/pipe_regfile_sb_if.sv
// pipe_regfile_sb_if: read, issue, writeback and flush signals between decode and the register file
interface pipe_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD-1:0]        rd_use;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  stall;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  flush;
  logic [ADDR_W:0]       pend_cnt;
  modport master (
    output rd_addr, rd_use, iss_en, iss_addr, wr_en, wr_addr, wr_data, flush,
    input  rd_data, rd_busy, stall, pend_cnt
  );
  modport slave (
    input  rd_addr, rd_use, iss_en, iss_addr, wr_en, wr_addr, wr_data, flush,
    output rd_data, rd_busy, stall, pend_cnt
  );
endinterface

// File: rtl/pipe_regfile_sb.sv
// pipe_regfile_sb: register file with per-register pending scoreboard and optional write-to-read bypass
module pipe_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  pipe_regfile_sb_if.slave bus
);
  localparam int NREG = 2**ADDR_W;
  logic [DATA_W-1:0]     regs_q [NREG];
  logic [DATA_W-1:0]     regs_d [NREG];
  logic [NREG-1:0]       pend_q, pend_d;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic                  wr_ok, iss_ok;
  logic [ADDR_W-1:0]     ra [NRD];
  logic [NRD-1:0]        hit, busy;
  logic [NRD*DATA_W-1:0] data;
  assign wr_ok  = bus.wr_en && bus.wr_addr != '0;
  assign iss_ok = bus.iss_en && bus.iss_addr != '0;
  // next state: register write, then pending bits where flush beats issue beats writeback-clear
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[bus.wr_addr] = bus.wr_data;
    pend_d = pend_q;
    if (wr_ok) pend_d[bus.wr_addr] = 1'b0;
    if (iss_ok) pend_d[bus.iss_addr] = 1'b1;
    if (bus.flush) pend_d = '0;
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
  end
  // state registers; the count tracks the popcount of the registered pending bits
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end
  // read ports: forward the writeback value and suppress busy when it retires the read register
  always_comb begin
    ra   = '{default: '0};
    hit  = '0;
    busy = '0;
    data = '0;
    for (int k = 0; k < NRD; k++) begin
      ra[k]   = bus.rd_addr[k*ADDR_W +: ADDR_W];
      hit[k]  = (BYPASS != 0) && wr_ok && bus.wr_addr == ra[k];
      busy[k] = pend_q[ra[k]] && ra[k] != '0 && !hit[k];
      data[k*DATA_W +: DATA_W] = hit[k] ? bus.wr_data : regs_q[ra[k]];
    end
  end
  assign bus.rd_data  = data;
  assign bus.rd_busy  = busy;
  assign bus.stall    = |(bus.rd_use & busy);
  assign bus.pend_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_regfile_sb.sv
// tb_pipe_regfile_sb: directed and short random stimulus against bypass-on and bypass-off instances
module tb_pipe_regfile_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_use;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        flush;
  int          checks = 0;
  int          errors = 0;
  logic        started = 1'b0;
  logic [31:0] m_reg [32];
  logic [31:0] m_pend;
  logic [1:0]  eb;
  always #5 clk = ~clk;
  pipe_regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) b1 ();
  pipe_regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) b0 ();
  assign b1.rd_addr  = rd_addr;
  assign b1.rd_use   = rd_use;
  assign b1.iss_en   = iss_en;
  assign b1.iss_addr = iss_addr;
  assign b1.wr_en    = wr_en;
  assign b1.wr_addr  = wr_addr;
  assign b1.wr_data  = wr_data;
  assign b1.flush    = flush;
  assign b0.rd_addr  = rd_addr;
  assign b0.rd_use   = rd_use;
  assign b0.iss_en   = iss_en;
  assign b0.iss_addr = iss_addr;
  assign b0.wr_en    = wr_en;
  assign b0.wr_addr  = wr_addr;
  assign b0.wr_data  = wr_data;
  assign b0.flush    = flush;
  pipe_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  pipe_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  function automatic logic [31:0] rdd(input int b, input int k);
    return b == 1 ? b1.rd_data[k*32 +: 32] : b0.rd_data[k*32 +: 32];
  endfunction
  function automatic logic bsy(input int b, input int k);
    return b == 1 ? b1.rd_busy[k] : b0.rd_busy[k];
  endfunction
  function automatic logic stl(input int b);
    return b == 1 ? b1.stall : b0.stall;
  endfunction
  function automatic logic [5:0] pc(input int b);
    return b == 1 ? b1.pend_cnt : b0.pend_cnt;
  endfunction
  function automatic logic fwd(input int b, input logic [4:0] a);
    return b == 1 && wr_en && a != 5'd0 && wr_addr == a;
  endfunction
  function automatic logic [31:0] e_data(input int b, input int k);
    logic [4:0] a;
    a = rd_addr[k*5 +: 5];
    return fwd(b, a) ? wr_data : m_reg[a];
  endfunction
  function automatic logic e_busy(input int b, input int k);
    logic [4:0] a;
    a = rd_addr[k*5 +: 5];
    return a != 5'd0 && m_pend[a] && !fwd(b, a);
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  // reference state: register values and pending set updated from the edge's inputs
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] <= 32'd0;
      m_pend  <= 32'd0;
      started <= 1'b1;
    end else begin
      if (wr_en && wr_addr != 5'd0) m_reg[wr_addr] <= wr_data;
      for (int i = 1; i < 32; i++)
        m_pend[i] <= flush ? 1'b0 : (iss_en && iss_addr == i) ? 1'b1 : (wr_en && wr_addr == i) ? 1'b0 : m_pend[i];
    end
  end
  // every cycle compare both instances against the reference
  always @(negedge clk) begin
    if (started) begin
      for (int b = 0; b < 2; b++) begin
        eb = '0;
        for (int k = 0; k < 2; k++) begin
          eb[k] = e_busy(b, k);
          chk($sformatf("rd_data%0d_bp%0d", k, b), 64'(rdd(b, k)), 64'(e_data(b, k)));
          chk($sformatf("rd_busy%0d_bp%0d", k, b), 64'(bsy(b, k)), 64'(eb[k]));
        end
        chk($sformatf("stall_bp%0d", b), 64'(stl(b)), 64'(|(rd_use & eb)));
        chk($sformatf("pend_cnt_bp%0d", b), 64'(pc(b)), 64'($countones(m_pend)));
      end
    end
  end
  task automatic nxt;
    @(posedge clk);
    #1;
    iss_en = 1'b0;
    wr_en  = 1'b0;
    flush  = 1'b0;
    rst    = 1'b0;
  endtask
  task automatic ra(input logic [4:0] p0, input logic [4:0] p1);
    rd_addr = {p1, p0};
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask
  task automatic iss(input logic [4:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask
  initial begin
    rst = 1'b1; rd_addr = '0; rd_use = '0; iss_en = 1'b0; iss_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ra(5, 3); rd_use = 2'b11;
    #1;
    chk("rst_data", 64'(rdd(1, 0)), 64'd0);
    chk("rst_busy", 64'(bsy(1, 1)), 64'd0);
    chk("rst_stall", 64'(stl(0)), 64'd0);
    chk("rst_cnt", 64'(pc(1)), 64'd0);
    rd_use = 2'b00;
    ra(0, 0); wr(5, 32'hDEADBEEF); nxt;
    ra(5, 5); #1;
    chk("wr5_bp1", 64'(rdd(1, 0)), 64'hDEADBEEF);
    chk("wr5_bp0", 64'(rdd(0, 0)), 64'hDEADBEEF);
    chk("dup_port", 64'(rdd(1, 1)), 64'hDEADBEEF);
    ra(0, 0); wr(0, 32'h1234); #1;
    chk("r0_nofwd", 64'(rdd(1, 0)), 64'd0);
    nxt; #1;
    chk("r0_zero", 64'(rdd(0, 0)), 64'd0);
    wr(7, 32'h11); nxt;
    ra(0, 7); wr(7, 32'h55); #1;
    chk("byp_data", 64'(rdd(1, 1)), 64'h55);
    chk("byp_busy", 64'(bsy(1, 1)), 64'd0);
    chk("nobyp_data", 64'(rdd(0, 1)), 64'h11);
    nxt; #1;
    chk("nobyp_late", 64'(rdd(0, 1)), 64'h55);
    iss(3); nxt;
    ra(3, 0); rd_use = 2'b01; #1;
    chk("haz_stall_bp1", 64'(stl(1)), 64'd1);
    chk("haz_stall_bp0", 64'(stl(0)), 64'd1);
    chk("haz_cnt", 64'(pc(1)), 64'd1);
    rd_use = 2'b00; #1;
    chk("haz_nouse", 64'(stl(1)), 64'd0);
    rd_use = 2'b01; wr(3, 32'h33); #1;
    chk("wb_stall_bp1", 64'(stl(1)), 64'd0);
    chk("wb_stall_bp0", 64'(stl(0)), 64'd1);
    nxt; #1;
    chk("after_wb_bp0", 64'(stl(0)), 64'd0);
    chk("after_wb_cnt", 64'(pc(0)), 64'd0);
    rd_use = 2'b00;
    iss(7); nxt;
    ra(0, 7); wr(7, 32'h66); #1;
    chk("wb_busy_bp1", 64'(bsy(1, 1)), 64'd0);
    chk("wb_busy_bp0", 64'(bsy(0, 1)), 64'd1);
    nxt;
    iss(9); nxt; #1;
    chk("col_pre_cnt", 64'(pc(1)), 64'd1);
    iss(9); wr(9, 32'h99); nxt;
    ra(9, 9); #1;
    chk("col_cnt", 64'(pc(1)), 64'd1);
    chk("col_busy", 64'(bsy(1, 0)), 64'd1);
    chk("col_data", 64'(rdd(1, 0)), 64'h99);
    wr(9, 32'h9A); nxt; #1;
    chk("col_clear", 64'(pc(1)), 64'd0);
    iss(2); nxt;
    iss(4); nxt;
    iss(6); nxt; #1;
    chk("fl_pre_cnt", 64'(pc(1)), 64'd3);
    flush = 1'b1; wr(4, 32'h77); nxt;
    ra(4, 6); #1;
    chk("fl_cnt", 64'(pc(1)), 64'd0);
    chk("fl_data", 64'(rdd(1, 0)), 64'h77);
    chk("fl_busy0", 64'(bsy(1, 0)), 64'd0);
    chk("fl_busy1", 64'(bsy(0, 1)), 64'd0);
    flush = 1'b1; iss(8); nxt;
    ra(8, 8); #1;
    chk("fl_iss_cnt", 64'(pc(1)), 64'd0);
    chk("fl_iss_busy", 64'(bsy(1, 0)), 64'd0);
    iss(10); wr(10, 32'hAA); nxt;
    ra(10, 11); #1;
    chk("mid_cnt", 64'(pc(1)), 64'd1);
    chk("mid_data", 64'(rdd(1, 0)), 64'hAA);
    chk("mid_busy", 64'(bsy(1, 0)), 64'd1);
    rst = 1'b1; iss(11); nxt; #1;
    chk("rst_mid_data", 64'(rdd(1, 0)), 64'd0);
    chk("rst_mid_cnt", 64'(pc(0)), 64'd0);
    chk("rst_mid_b10", 64'(bsy(1, 0)), 64'd0);
    chk("rst_mid_b11", 64'(bsy(1, 1)), 64'd0);
    for (int n = 0; n < 80; n++) begin
      rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rd_use   = 2'($urandom_range(0, 3));
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = 5'($urandom_range(0, 7));
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      flush    = $urandom_range(0, 15) == 0;
      rst      = $urandom_range(0, 39) == 0;
      nxt;
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_regfile_sb.md
PIPE_REGFILE_SB -- requirements
Module: pipe_regfile_sb

Parameters
REQ-001 The block SHALL provide parameters, one per line:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width; register count NREG = 2**ADDR_W.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, enables same-cycle write-to-read forwarding (1 = on, 0 = off).

Interface
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 It SHALL expose these ports, one per line (name, direction, width, meaning):
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- rd_addr  in  NRD*ADDR_W  packed read indices; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_use  in  NRD  port k operand is actually consumed by the instruction in decode.
- rd_data  out  NRD*DATA_W  packed read data, combinational.
- rd_busy  out  NRD  port k operand has a pending producer.
- stall  out  1  OR over k of (rd_use[k] & rd_busy[k]).
- iss_en  in  1  decode issues an instruction that will write iss_addr.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- wr_en  in  1  writeback valid.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback value.
- flush  in  1  clear all pending marks (branch squash).
- pend_cnt  out  ADDR_W+1  number of registers currently marked pending.

Function
REQ-004 Register 0 SHALL always read 0; writes to it SHALL be ignored; it SHALL never be marked pending.
REQ-005 rd_data[k] SHALL be REG[rd_addr[k]], with one exception: when BYPASS=1, wr_en=1, wr_addr=rd_addr[k] and wr_addr!=0, it SHALL be wr_data in the same cycle.
REQ-006 On a rising edge with wr_en=1 and wr_addr!=0, REG[wr_addr] SHALL take wr_data; the value SHALL be visible on all read ports the following cycle.
REQ-007 The scoreboard SHALL hold one pending bit per register, PEND[0..NREG-1].
REQ-008 PEND SHALL update on each edge in priority order, highest first:
- rst: all bits clear.
- flush: all bits clear.
- iss_en with iss_addr!=0: PEND[iss_addr] set.
- wr_en with wr_addr!=0: PEND[wr_addr] cleared.
REQ-009 When the issue and the writeback target the same register in the same cycle, PEND SHALL end set, because the new producer wins.
REQ-010 flush SHALL NOT block a same-cycle register write; the REG write still occurs.
REQ-011 rd_busy[k] SHALL be 1 when PEND[rd_addr[k]]=1 and rd_addr[k]!=0, except that it SHALL be 0 in a cycle where BYPASS=1 and the writeback in that cycle clears that same register.
REQ-012 With BYPASS=0, rd_busy SHALL depend only on the registered PEND state.
REQ-013 rd_busy and stall SHALL NOT depend on same-cycle iss_en.
REQ-014 The block SHALL never block iss_en; upstream must not assert iss_en while stall=1.
REQ-015 pend_cnt SHALL equal the population count of the registered PEND bits.
REQ-016 pend_cnt SHALL update one cycle after any change to PEND and SHALL saturate naturally at NREG-1.
REQ-017 Read-port duplicates (same address on two ports) SHALL return identical data and identical busy values.

Reset
REQ-018 When rst is high at a rising edge, the block SHALL clear all REG entries, all PEND bits and pend_cnt to 0.
REQ-019 rst SHALL override flush, iss_en and wr_en in the same cycle.
REQ-020 Outputs SHALL be valid (rd_data 0, rd_busy 0, stall 0) in the first cycle after reset.
REQ-021 A reset asserted between issue and writeback SHALL leave no stale pending bit.

Verification
REQ-022 Write then read: wr_en, wr_addr=5, wr_data=0xDEADBEEF; next cycle rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF. Write to register 0 with 0x1234 -> reads 0.
REQ-023 Bypass: same cycle wr_addr=7, wr_data=0x55, rd_addr[1]=7, old REG[7]=0x11 -> with BYPASS=1, rd_data[1]=0x55 and rd_busy[1]=0; with BYPASS=0, rd_data[1]=0x11.
REQ-024 Hazard stall:
- Issue to register 3 -> next cycle rd_addr[0]=3 with rd_use[0]=1 gives stall=1 and pend_cnt=1.
- rd_use[0]=0 -> stall=0.
- Writeback to register 3 -> stall drops in the writeback cycle (BYPASS=1) or the cycle after (BYPASS=0).
REQ-025 Collision: PEND[9]=1, same cycle iss_en and wr_en both at 9 -> PEND[9] stays 1 and pend_cnt is unchanged.
REQ-026 Flush:
- Issue to registers 2, 4 and 6 -> pend_cnt=3.
- flush together with wr_en to 4 (value 0x77) -> next cycle pend_cnt=0, REG[4]=0x77 and no rd_busy is set.
REQ-027 Reset mid-operation:
- Set PEND[10] and REG[10]=0xAA.
- Assert rst together with iss_en to 11 -> next cycle REG[10]=0, PEND all 0, pend_cnt=0.
